// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: sequential fetch with a req/gnt credit rule, an
// in-order response FIFO toward decode, and redirect/flush with stale-response dropping.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  input  logic        id_stall
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);
  localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [31:0]      fetch_pc_reg, fetch_pc_next;
  logic [31:0]      resp_pc_reg, resp_pc_next;
  logic [OCC_W-1:0] occ_reg, occ_next;
  logic [OUT_W-1:0] outstanding_reg, outstanding_next;
  logic [OUT_W-1:0] drop_cnt_reg, drop_cnt_next;
  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;

  logic [DEPTH-1:0][31:0] pc_ent;
  logic [DEPTH-1:0][31:0] instr_ent;

  logic credit_ok;
  logic accept;
  logic resp;
  logic drop;
  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  // Credits count both buffered words and words still in flight, so the FIFO
  // always has room for every response that can come back.
  always_comb begin
    credit_ok = (int'(outstanding_reg) < MAX_OUT) &&
                (int'(occ_reg) + int'(outstanding_reg) < DEPTH);
  end

  assign imem_req  = !clr && !redirect && credit_ok;
  assign imem_addr = fetch_pc_reg;
  assign accept    = imem_req && imem_gnt;
  assign resp      = imem_rvalid && (outstanding_reg != '0);
  assign drop      = resp && (drop_cnt_reg != '0);
  assign push      = resp && !drop && !redirect;
  assign id_valid  = !clr && (occ_reg != '0);
  assign pop       = id_valid && !id_stall && !redirect;
  assign id_pc     = pc_ent[head_reg];
  assign id_instr  = instr_ent[head_reg];

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    resp_pc_next     = resp_pc_reg;
    occ_next         = occ_reg;
    outstanding_next = outstanding_reg;
    drop_cnt_next    = drop_cnt_reg;
    head_next        = head_reg;
    tail_next        = tail_reg;

    if (accept) begin
      fetch_pc_next = fetch_pc_reg + 32'd4;
    end

    case ({accept, resp})
      2'b10:   outstanding_next = outstanding_reg + OUT_ONE;
      2'b01:   outstanding_next = outstanding_reg - OUT_ONE;
      default: outstanding_next = outstanding_reg;
    endcase

    if (redirect) begin
      // Everything still in flight after this edge belongs to the old path.
      fetch_pc_next = redirect_pc;
      resp_pc_next  = redirect_pc;
      occ_next      = '0;
      head_next     = '0;
      tail_next     = '0;
      drop_cnt_next = resp ? (outstanding_reg - OUT_ONE) : outstanding_reg;
    end else begin
      if (drop) begin
        drop_cnt_next = drop_cnt_reg - OUT_ONE;
      end
      if (push) begin
        resp_pc_next = resp_pc_reg + 32'd4;
        tail_next    = ptr_inc(tail_reg);
      end
      if (pop) begin
        head_next = ptr_inc(head_reg);
      end
      case ({push, pop})
        2'b10:   occ_next = occ_reg + OCC_ONE;
        2'b01:   occ_next = occ_reg - OCC_ONE;
        default: occ_next = occ_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      occ_reg         <= '0;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
      head_reg        <= '0;
      tail_reg        <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      occ_reg         <= occ_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
      head_reg        <= head_next;
      tail_reg        <= tail_next;
    end
  end

  // Entry payload needs no reset; occ gates its visibility.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [31:0] pc_reg;
      logic [31:0] instr_reg;

      always_ff @(posedge clk) begin
        if (push && (tail_reg == PTR_W'(gi))) begin
          pc_reg    <= resp_pc_reg;
          instr_reg <= imem_rdata;
        end
      end

      assign pc_ent[gi]    = pc_reg;
      assign instr_ent[gi] = instr_reg;
    end
  endgenerate

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: in-order imem model with controllable
// response release, and an expected-PC scoreboard checked on every decode pop.
module tb_ifetch_queue;

  logic        clk;
  logic        clr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_stall;

  logic resp_en;
  logic flush_mem;
  logic stale_flag;

  logic [31:0] exp_q[$];
  int exp_rd;
  int n_cmp;
  int n_err;

  ifetch_queue #(.DEPTH(4), .MAX_OUT(2), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .clr(clr),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .id_valid(id_valid),
    .id_pc(id_pc),
    .id_instr(id_instr),
    .id_stall(id_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a ^ 32'hC0DE_0000) + 32'h11;
  endfunction

  // Instruction memory: records accepts before the edge, returns them in order
  // one cycle later when resp_en is set; can inject one stale word or forget all.
  initial begin
    logic [31:0] pend_q[$];
    logic [31:0] a;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (imem_req && imem_gnt) pend_q.push_back(imem_addr);
      @(posedge clk);
      #2;
      if (flush_mem) pend_q.delete();
      if (stale_flag) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
      end else if (resp_en && pend_q.size() > 0) begin
        a = pend_q.pop_front();
        imem_rvalid = 1'b1;
        imem_rdata  = word_of(a);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Sample point mid-cycle; every decode pop is scored against the expected queue.
  task automatic run_cycle();
    logic [31:0] e;
    @(negedge clk);
    if (!clr && !redirect && id_valid && !id_stall && exp_rd < exp_q.size()) begin
      e = exp_q[exp_rd];
      exp_rd++;
      n_cmp++;
      if (id_pc !== e || id_instr !== word_of(e)) begin
        n_err++;
        $display("FAIL pop: got pc=%h instr=%h, want pc=%h instr=%h", id_pc, id_instr, e, word_of(e));
      end else begin
        $display("pop  pc=%h instr=%h", id_pc, id_instr);
      end
    end
  endtask

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (exp_rd < exp_q.size() && k < 60) begin
      run_cycle();
      next_drive();
      k++;
    end
    n_cmp++;
    if (exp_rd != exp_q.size()) begin
      n_err++;
      $display("FAIL %s drain: got %0d pops, want %0d", tag, exp_rd, exp_q.size());
      exp_rd = exp_q.size();
    end
  endtask

  task automatic do_reset();
    clr = 1'b1; redirect = 1'b0; redirect_pc = '0; id_stall = 1'b0;
    imem_gnt = 1'b1; resp_en = 1'b1; flush_mem = 1'b1; stale_flag = 1'b0;
    run_cycle(); next_drive();
    run_cycle(); next_drive();
    clr = 1'b0; flush_mem = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; redirect = 1'b1; redirect_pc = 32'h1234; id_stall = 1'b0;
    imem_gnt = 1'b1; resp_en = 1'b1; flush_mem = 1'b1; stale_flag = 1'b0;
    run_cycle();
    n_cmp++;
    if ({imem_req, id_valid} !== 2'b00) begin
      n_err++; $display("FAIL reset_outs: got req/valid=%b, want 00", {imem_req, id_valid});
    end
    next_drive();
    run_cycle(); next_drive();
    clr = 1'b0; redirect = 1'b0; flush_mem = 1'b0;
    run_cycle();
    n_cmp++;
    if ({imem_req, id_valid} !== 2'b10) begin
      n_err++; $display("FAIL reset_req: got req/valid=%b, want 10", {imem_req, id_valid});
    end
    n_cmp++;
    if (imem_addr !== 32'h0) begin
      n_err++; $display("FAIL reset_pc: got %h, want 00000000", imem_addr);
    end
    next_drive();
  endtask

  task automatic test_free_run();
    logic [31:0] want;
    do_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    run_cycle();
    n_cmp++;
    if ({imem_req, id_valid, imem_addr} !== {2'b10, 32'h0}) begin
      n_err++; $display("FAIL run_c0: got req/valid=%b addr=%h, want 10/0", {imem_req, id_valid}, imem_addr);
    end
    next_drive();
    run_cycle();
    n_cmp++;
    if ({imem_req, id_valid, imem_addr} !== {2'b10, 32'h4}) begin
      n_err++; $display("FAIL run_c1: got req/valid=%b addr=%h, want 10/4", {imem_req, id_valid}, imem_addr);
    end
    next_drive();
    for (int i = 0; i < 4; i++) begin
      want = 32'(i * 4);
      run_cycle();
      n_cmp++;
      if ({id_valid, id_pc} !== {1'b1, want}) begin
        n_err++; $display("FAIL run_seq%0d: got valid=%b pc=%h, want 1/%h", i, id_valid, id_pc, want);
      end
      next_drive();
    end
    wait_drain("free_run");
  endtask

  task automatic test_stall();
    do_reset();
    id_stall = 1'b1;
    for (int i = 0; i < 10; i++) exp_q.push_back(32'(i * 4));
    for (int c = 0; c < 6; c++) begin
      run_cycle();
      if (c == 5) begin
        n_cmp++;
        if ({imem_req, id_valid, id_pc, imem_addr} !== {2'b01, 32'h0, 32'h10}) begin
          n_err++;
          $display("FAIL stall_sat: got req/valid=%b pc=%h addr=%h, want 01/0/10", {imem_req, id_valid}, id_pc, imem_addr);
        end
      end
      next_drive();
    end
    id_stall = 1'b0;
    wait_drain("stall");
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    imem_gnt = 1'b0; resp_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h10;
    run_cycle(); next_drive();
    redirect = 1'b0; imem_gnt = 1'b1;
    run_cycle();
    n_cmp++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h10}) begin
      n_err++; $display("FAIL rd_first: got req=%b addr=%h, want 1/10", imem_req, imem_addr);
    end
    next_drive();
    run_cycle(); next_drive();
    run_cycle();
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_err++; $display("FAIL rd_maxout: got req=%b, want 0", imem_req);
    end
    next_drive();
    redirect = 1'b1; redirect_pc = 32'h200;
    run_cycle(); next_drive();
    redirect = 1'b0; resp_en = 1'b1;
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    run_cycle();
    n_cmp++;
    if ({id_valid, imem_addr} !== {1'b0, 32'h200}) begin
      n_err++; $display("FAIL rd_target: got valid=%b addr=%h, want 0/200", id_valid, imem_addr);
    end
    next_drive();
    wait_drain("redirect_inflight");
  endtask

  task automatic test_redirect_collide();
    do_reset();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    for (int c = 0; c < 4; c++) begin
      run_cycle(); next_drive();
    end
    redirect = 1'b1; redirect_pc = 32'h300;
    run_cycle();
    n_cmp++;
    if ({imem_req, id_valid, id_pc} !== {2'b01, 32'h8}) begin
      n_err++; $display("FAIL col_pre: got req/valid=%b pc=%h, want 01/8", {imem_req, id_valid}, id_pc);
    end
    next_drive();
    redirect = 1'b0;
    run_cycle();
    n_cmp++;
    if ({imem_req, id_valid, imem_addr} !== {2'b10, 32'h300}) begin
      n_err++; $display("FAIL col_post: got req/valid=%b addr=%h, want 10/300", {imem_req, id_valid}, imem_addr);
    end
    next_drive();
    exp_q.push_back(32'h300);
    exp_q.push_back(32'h304);
    wait_drain("redirect_collide");
  endtask

  task automatic test_wrap();
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    run_cycle(); next_drive();
    redirect = 1'b0;
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    wait_drain("wrap");
  endtask

  task automatic test_clr_inflight();
    do_reset();
    resp_en = 1'b0;
    run_cycle(); next_drive();
    run_cycle(); next_drive();
    run_cycle();
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_err++; $display("FAIL clr_maxout: got req=%b, want 0", imem_req);
    end
    next_drive();
    clr = 1'b1;
    run_cycle();
    n_cmp++;
    if ({imem_req, id_valid} !== 2'b00) begin
      n_err++; $display("FAIL clr_outs: got req/valid=%b, want 00", {imem_req, id_valid});
    end
    next_drive();
    clr = 1'b0; flush_mem = 1'b1; stale_flag = 1'b1; resp_en = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    run_cycle();
    n_cmp++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL clr_restart: got req=%b addr=%h, want 1/0", imem_req, imem_addr);
    end
    next_drive();
    flush_mem = 1'b0; stale_flag = 1'b0;
    wait_drain("clr_inflight");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_rd = 0;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_inflight();
    test_redirect_collide();
    test_wrap();
    test_clr_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
